// File: rtl/popcnt_window_acc.sv
// Sliding-window accumulator for a streaming popcount: sums the last WIN accepted samples and
// presents each updated sum with full/over flags through a registered valid/ready stage.
module popcnt_window_acc #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned WIN    = 8,
    parameter int unsigned THRESH = 128,
    localparam int unsigned SUM_W = CNT_W + $clog2(WIN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             in_valid_i,
    input  logic [CNT_W-1:0] in_count_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [SUM_W-1:0] out_sum_o,
    output logic             out_full_o,
    output logic             out_over_o
);

    localparam int unsigned PTR_W = $clog2(WIN);
    localparam logic [PTR_W-1:0] LastPtr = PTR_W'(WIN - 1);

    typedef enum logic [0:0] {
        StFilling,
        StSteady
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   mem_q [WIN];

    logic               out_valid_q, out_valid_d;
    logic [SUM_W-1:0]   out_sum_q, out_sum_d;
    logic               out_full_q, out_full_d;
    logic               out_over_q, out_over_d;

    logic               accept;
    logic [CNT_W-1:0]   old_sample;
    logic [SUM_W-1:0]   sum_n;
    state_e             state_n;

    assign in_ready_o  = rst && !clr_i && (!out_valid_q || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;

    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_full_o  = out_full_q;
    assign out_over_o  = out_over_q;

    // While filling, the fill count equals wr_ptr_q, so the pointer doubles as the fill counter.
    always_comb begin
        old_sample = (state_q == StSteady) ? mem_q[wr_ptr_q] : '0;
        sum_n      = sum_q + SUM_W'(in_count_i) - SUM_W'(old_sample);
        state_n    = state_q;
        if (state_q == StFilling && wr_ptr_q == LastPtr) begin
            state_n = StSteady;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_full_d  = out_full_q;
        out_over_d  = out_over_q;

        if (clr_i) begin
            state_d     = StFilling;
            wr_ptr_d    = '0;
            sum_d       = '0;
            out_valid_d = 1'b0;
            out_sum_d   = '0;
            out_full_d  = 1'b0;
            out_over_d  = 1'b0;
        end else if (accept) begin
            state_d     = state_n;
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            sum_d       = sum_n;
            out_valid_d = 1'b1;
            out_sum_d   = sum_n;
            out_full_d  = (state_n == StSteady);
            out_over_d  = (32'(sum_n) >= THRESH);
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StFilling;
            wr_ptr_q    <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_full_q  <= 1'b0;
            out_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_full_q  <= out_full_d;
            out_over_q  <= out_over_d;
        end
    end

    // Sample storage needs no reset: entries are only read once the window has been filled.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= in_count_i;
        end
    end

endmodule
